sub_bla_pipe: RTL and testbench

//  32-bit subtractor D = A - B - Bin using 4-bit borrow-lookahead groups; the inverse datapath of the adder_cla block.
//  Two-stage pipeline with valid/ready handshake at input and output.

---
 rtl/sub_bla_pkg.sv | 14 +
 rtl/sub_bla_pipe_bla_4bit.sv | 26 ++
 rtl/sub_bla_pipe.sv | 107 ++++++++++
 tb/tb_sub_bla_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_bla_pkg.sv
// Shared constants and the group borrow-lookahead equation for the sub_bla_pipe subtractor.
package sub_bla_pkg;
   localparam int WIDTH     = 32;
   localparam int GRP       = 4;
   localparam int HALF      = WIDTH / 2;
   localparam int NGRP_HALF = HALF / GRP;

   function automatic logic bla_bout(input logic [GRP-1:0] g,
                                     input logic [GRP-1:0] p,
                                     input logic           bin);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
             (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);
   endfunction
endpackage

// File: rtl/sub_bla_pipe_bla_4bit.sv
// One 4-bit borrow-lookahead subtractor group: d = a - b - bin, with group borrow out.
module bla_4bit
   import sub_bla_pkg::*;
(
   input  logic [GRP-1:0] a_i,
   input  logic [GRP-1:0] b_i,
   input  logic           bin_i,
   output logic [GRP-1:0] d_o,
   output logic           bout_o
);
   logic [GRP-1:0] g;
   logic [GRP-1:0] p;
   logic [GRP-1:0] bcar;

   assign g = ~a_i & b_i;
   assign p = ~(a_i ^ b_i);

   // Borrow into each bit, expanded from the group g/p terms rather than rippled.
   assign bcar[0] = bin_i;
   assign bcar[1] = g[0] | (p[0] & bin_i);
   assign bcar[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin_i);
   assign bcar[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin_i);

   assign d_o    = a_i ^ b_i ^ bcar;
   assign bout_o = bla_bout(g, p, bin_i);
endmodule

// File: rtl/sub_bla_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor D = A - B - Bin with valid/ready on both sides.
// Define SUB_BLA_FLAGS_EN to add the registered zero (Z_o) and signed-overflow (V_o) flags.
module sub_bla_pipe
   import sub_bla_pkg::*;
#(
   parameter int WIDTH = sub_bla_pkg::WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             Bin_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] D_o,
   output logic             Bout_o,
   input  logic             out_ready_i,
   output logic             out_valid_o
`ifdef SUB_BLA_FLAGS_EN
   ,
   output logic             Z_o,
   output logic             V_o
`endif
);
   localparam int HW = WIDTH / 2;
   localparam int NG = HW / GRP;

   logic          s1_valid_q, s1_valid_d;
   logic          s2_valid_q, s2_valid_d;
   logic [HW-1:0] a_hi_q, b_hi_q, d_lo_q;
   logic          bmid_q;
   logic [WIDTH-1:0] d_q;
   logic          bout_q;

   logic          in_fire, s2_load;
   logic [HW-1:0] d_lo, d_hi;
   logic [NG:0]   bl, bh;

   assign in_ready_o = ~s1_valid_q | ~s2_valid_q | out_ready_i;
   assign in_fire    = in_valid_i & in_ready_o;
   assign s2_load    = s1_valid_q & (~s2_valid_q | out_ready_i);
   assign s1_valid_d = in_fire | (s1_valid_q & ~s2_load);
   assign s2_valid_d = s2_load | (s2_valid_q & ~out_ready_i);

   // Groups ripple inside a half only; the halves are split by the stage register.
   assign bl[0] = Bin_i;
   assign bh[0] = bmid_q;
   for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      bla_4bit u_lo (
         .a_i   (A_i[gi*GRP +: GRP]),
         .b_i   (B_i[gi*GRP +: GRP]),
         .bin_i (bl[gi]),
         .d_o   (d_lo[gi*GRP +: GRP]),
         .bout_o(bl[gi+1])
      );
      bla_4bit u_hi (
         .a_i   (a_hi_q[gi*GRP +: GRP]),
         .b_i   (b_hi_q[gi*GRP +: GRP]),
         .bin_i (bh[gi]),
         .d_o   (d_hi[gi*GRP +: GRP]),
         .bout_o(bh[gi+1])
      );
   end

   always_ff @(posedge clk_i) begin
      if (in_fire) begin
         a_hi_q <= A_i[WIDTH-1:HW];
         b_hi_q <= B_i[WIDTH-1:HW];
         d_lo_q <= d_lo;
         bmid_q <= bl[NG];
      end
   end

`ifdef SUB_BLA_FLAGS_EN
   logic z_q, v_q;
   assign Z_o = z_q;
   assign V_o = v_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         d_q        <= '0;
         bout_q     <= 1'b0;
`ifdef SUB_BLA_FLAGS_EN
         z_q        <= 1'b0;
         v_q        <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            d_q    <= {d_hi, d_lo_q};
            bout_q <= bh[NG];
`ifdef SUB_BLA_FLAGS_EN
            z_q    <= ({d_hi, d_lo_q} == '0);
            v_q    <= (a_hi_q[HW-1] != b_hi_q[HW-1]) & (d_hi[HW-1] != a_hi_q[HW-1]);
`endif
         end
      end
   end

   assign D_o         = d_q;
   assign Bout_o      = bout_q;
   assign out_valid_o = s2_valid_q;
endmodule

// File: tb/tb_sub_bla_pipe.sv
// Randomized and directed bench for sub_bla_pipe against an arithmetic reference model.
module tb_sub_bla_pipe;
   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [W-1:0] A_i, B_i;
   logic         Bin_i, in_valid_i, in_ready_o;
   logic [W-1:0] D_o;
   logic         Bout_o, out_valid_o, out_ready_i;
`ifdef SUB_BLA_FLAGS_EN
   logic         Z_o, V_o;
`endif

   always #5 clk_i = ~clk_i;

   sub_bla_pipe #(.WIDTH(W)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .A_i        (A_i),
      .B_i        (B_i),
      .Bin_i      (Bin_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .D_o        (D_o),
      .Bout_o     (Bout_o),
      .out_ready_i(out_ready_i),
      .out_valid_o(out_valid_o)
`ifdef SUB_BLA_FLAGS_EN
      ,
      .Z_o        (Z_o),
      .V_o        (V_o)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference: {bout, d, z, v} from plain unsigned and signed arithmetic.
   function automatic logic [34:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      logic [32:0] t;
      longint      r;
      logic        v;
      t = {1'b0, a} - {1'b0, b} - {32'd0, bin};
      r = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return {t[32], t[31:0], (t[31:0] == 32'd0), v};
   endfunction

   logic [34:0] exp_q[$];
   int          n_out = 0;
   logic        stall_prev = 1'b0;
   logic [W:0]  prev_out;

   always @(negedge clk_i) begin
      logic [34:0] e;
      if (rst_i) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(out_valid_o), 64'd1);
            check("stall_data", 64'({Bout_o, D_o}), 64'(prev_out));
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("D", 64'(D_o), 64'(e[33:2]));
               check("Bout", 64'(Bout_o), 64'(e[34]));
`ifdef SUB_BLA_FLAGS_EN
               check("Z", 64'(Z_o), 64'(e[1]));
               check("V", 64'(V_o), 64'(e[0]));
`endif
            end
            n_out++;
         end
         if (in_valid_i && in_ready_o) exp_q.push_back(model(A_i, B_i, Bin_i));
         stall_prev = out_valid_o && !out_ready_i;
         prev_out   = {Bout_o, D_o};
      end
   end

   task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                           input logic [W-1:0] ed, input logic eb, input logic ez, input logic ev);
      A_i = a; B_i = b; Bin_i = bin; in_valid_i = 1'b1;
      check("dir_ready", 64'(in_ready_o), 64'd1);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check("dir_lat1", 64'(out_valid_o), 64'd0);
      @(posedge clk_i); #1;
      check("dir_lat2", 64'(out_valid_o), 64'd1);
      check("dir_D", 64'(D_o), 64'(ed));
      check("dir_Bout", 64'(Bout_o), 64'(eb));
`ifdef SUB_BLA_FLAGS_EN
      check("dir_Z", 64'(Z_o), 64'(ez));
      check("dir_V", 64'(V_o), 64'(ev));
`else
      if (ez && ev) $display("note: Z and V both expected set");
`endif
      $display("op A=%08h B=%08h Bin=%0d -> D=%08h Bout=%0d", a, b, bin, D_o, Bout_o);
      @(posedge clk_i); #1;
   endtask

   initial begin
      logic [W-1:0] va[8], vb[8];
      logic         vbin[8];
      int idx, base, sent, cyc;

      rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
      A_i = '0; B_i = '0; Bin_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_D", 64'(D_o), 64'd0);
      check("rst_Bout", 64'(Bout_o), 64'd0);
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;

      directed(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
      directed(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      directed(32'd0, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      directed(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
      directed(32'h1234, 32'h1234, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

      // Back-to-back burst with a 3-cycle output stall.
      for (int i = 0; i < 8; i++) begin
         va[i] = $urandom; vb[i] = $urandom; vbin[i] = 1'($urandom_range(0, 1));
      end
      idx = 0;
      base = n_out;
      for (int c = 0; c < 40 && (idx < 8 || exp_q.size() != 0); c++) begin
         out_ready_i = !(c >= 3 && c < 6);
         if (idx < 8) begin
            in_valid_i = 1'b1; A_i = va[idx]; B_i = vb[idx]; Bin_i = vbin[idx];
         end else begin
            in_valid_i = 1'b0;
         end
         @(negedge clk_i);
         if (c == 3) check("t4_in_ready_drop", 64'(in_ready_o), 64'd0);
         if (in_valid_i && in_ready_o) idx++;
         @(posedge clk_i); #1;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      check("t4_sent", 64'(idx), 64'd8);
      check("t4_received", 64'(n_out - base), 64'd8);
      check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("burst of 8 with stall: received %0d", n_out - base);

      // Random traffic with random backpressure.
      sent = 0;
      cyc = 0;
      while (sent < 10000 && cyc < 40000) begin
         in_valid_i  = ($urandom_range(0, 3) != 0);
         A_i         = $urandom;
         B_i         = ($urandom_range(0, 15) == 0) ? A_i : $urandom;
         Bin_i       = 1'($urandom_range(0, 1));
         out_ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         if (in_valid_i && in_ready_o) sent++;
         @(posedge clk_i); #1;
         cyc++;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
         @(posedge clk_i); #1;
      end
      check("t5_sent", 64'(sent), 64'd10000);
      check("t5_drained", 64'(exp_q.size()), 64'd0);
      $display("random: %0d ops in %0d cycles", sent, cyc);

      // Reset while both stages hold data.
      out_ready_i = 1'b0;
      in_valid_i = 1'b1; A_i = $urandom; B_i = $urandom; Bin_i = 1'b0;
      @(posedge clk_i); #1;
      A_i = $urandom; B_i = $urandom; Bin_i = 1'b1;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      check("t6_full_valid", 64'(out_valid_o), 64'd1);
      check("t6_full_ready", 64'(in_ready_o), 64'd0);
      #2 rst_i = 1'b1;
      #1;
      check("t6_rst_valid", 64'(out_valid_o), 64'd0);
      check("t6_rst_ready", 64'(in_ready_o), 64'd1);
      exp_q.delete();
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      out_ready_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         check("t6_no_stale", 64'(out_valid_o), 64'd0);
      end
      @(posedge clk_i); #1;
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
